// File: rtl/access_pkg.sv
// Shared widths, table sizes, default credential tables and the
// password-change FSM encoding for the credential store.
package access_pkg;

  localparam int ID_W      = 16;  // 4 BCD digits
  localparam int PASS_W    = 20;  // 5 hex digits
  localparam int ADDR_W    = 4;
  localparam int NUM_USERS = 6;   // populated entries 0..NUM_USERS-1, at most 16
  localparam int GUEST_IDX = 5;   // entry whose password is locked

  // Index width into the populated tables, and init counter width (counts to NUM_USERS).
  localparam int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int CNT_W = $clog2(NUM_USERS + 1);

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [PASS_W-1:0] pass_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam id_t DEFAULT_ID [NUM_USERS] = '{
    16'h9489, 16'h3842, 16'h8321, 16'h5114, 16'h5297, 16'h1234
  };

  localparam pass_t DEFAULT_PASS [NUM_USERS] = '{
    20'h77777, 20'h11111, 20'hFFFFF, 20'hABCDE, 20'h07734, 20'h12345
  };

  typedef enum logic [2:0] {
    C_IDLE,
    C_CHECK,
    C_WRITE,
    C_ACK,
    C_ERR,
    C_HOLD
  } chg_state_e;

  // A change is allowed only for a populated, non-guest entry.
  function automatic logic chg_allowed(input addr_t a);
    return (int'(a) < NUM_USERS) && (int'(a) != GUEST_IDX);
  endfunction

endpackage

// File: rtl/cred_rd_pipe.sv
// Two-stage registered table read: stage 1 captures the address, stage 2
// captures the selected word. Out-of-range addresses, or reads while
// disabled, return zero with valid low.
module cred_rd_pipe #(
  parameter int DW    = 16,
  parameter int DEPTH = 6,
  parameter int AW    = 4,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rows [DEPTH],
  output logic [DW-1:0] q,
  output logic          q_valid
);

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] q_q, q_d;
  logic          valid_q, valid_d;

  // Stage-2 data select with range and enable check.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    addr_d  = addr;
    q_d     = '0;
    valid_d = 1'b0;
    if (en && (int'(addr_q) < DEPTH)) begin
      q_d     = rows[addr_q[IW-1:0]];
      valid_d = 1'b1;
    end
  end

  // Pipeline registers for the address and the read result.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst) begin
      addr_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q       = q_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/credential_store.sv
// Credential lookup responder: constant ID table and writable password table
// behind identical 2-cycle read pipelines, a post-reset password loader, and
// a request/acknowledge password-change FSM.
module credential_store
  import access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address_id,
  input  logic [3:0]  address_pass,
  output logic [ID_W-1:0]   q_id,
  output logic [PASS_W-1:0] q_pass,
  output logic        q_id_valid,
  output logic        q_pass_valid,
  output logic        init_done,
  input  logic        chg_req,
  input  logic [3:0]  chg_addr,
  input  logic [PASS_W-1:0] chg_pass,
  output logic        chg_ack,
  output logic        chg_err
);

  id_t              id_rom   [NUM_USERS];
  pass_t            pass_mem [NUM_USERS];

  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;

  chg_state_e       state_q;
  addr_t            chg_addr_q;
  pass_t            chg_pass_q;
  logic             chg_ack_q, chg_err_q;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  pass_t            wr_data;

  // Constant ID table feeding the ID read pipeline.
  always_comb begin
    for (int i = 0; i < NUM_USERS; i++) id_rom[i] = DEFAULT_ID[i];
  end

  // Loader progress: one default entry per cycle, done one edge after the last write.
  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (int'(init_cnt_q) < NUM_USERS) init_cnt_d  = init_cnt_q + 1'b1;
    else                              init_done_d = 1'b1;
  end

  // Loader counter and done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Single password write port: loader before init_done, change FSM after.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (!init_done_q) begin
      if (int'(init_cnt_q) < NUM_USERS) begin
        wr_en   = 1'b1;
        wr_idx  = init_cnt_q[IDX_W-1:0];
        wr_data = DEFAULT_PASS[init_cnt_q[IDX_W-1:0]];
      end
    end else if (state_q == C_WRITE) begin
      wr_en   = 1'b1;
      wr_idx  = chg_addr_q[IDX_W-1:0];
      wr_data = chg_pass_q;
    end
  end

  // Password storage.
  always_ff @(posedge clk) begin
    // NOTE: storage array has no reset; the loader rewrites every entry after each reset instead.
    if (wr_en) pass_mem[wr_idx] <= wr_data;
  end

  // Password-change FSM with registered one-cycle ack/err pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= C_IDLE;
      chg_addr_q <= '0;
      chg_pass_q <= '0;
      chg_ack_q  <= 1'b0;
      chg_err_q  <= 1'b0;
    end else begin
      chg_ack_q <= 1'b0;
      chg_err_q <= 1'b0;
      unique case (state_q)
        C_IDLE: begin
          if (chg_req && init_done_q) begin
            chg_addr_q <= chg_addr;
            chg_pass_q <= chg_pass;
            state_q    <= C_CHECK;
          end
        end
        C_CHECK: begin
          if (chg_allowed(chg_addr_q)) begin
            state_q <= C_WRITE;
          end else begin
            state_q   <= C_ERR;
            chg_err_q <= 1'b1;
          end
        end
        C_WRITE: begin
          state_q   <= C_ACK;
          chg_ack_q <= 1'b1;
        end
        C_ACK, C_ERR: state_q <= C_HOLD;
        C_HOLD: if (!chg_req) state_q <= C_IDLE;
        default: state_q <= C_IDLE;
      endcase
    end
  end

  cred_rd_pipe #(.DW(ID_W), .DEPTH(NUM_USERS), .AW(ADDR_W), .IW(IDX_W)) u_id_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (init_done_q),
    .addr    (address_id),
    .rows    (id_rom),
    .q       (q_id),
    .q_valid (q_id_valid)
  );

  cred_rd_pipe #(.DW(PASS_W), .DEPTH(NUM_USERS), .AW(ADDR_W), .IW(IDX_W)) u_pass_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (init_done_q),
    .addr    (address_pass),
    .rows    (pass_mem),
    .q       (q_pass),
    .q_valid (q_pass_valid)
  );

  assign init_done = init_done_q;
  assign chg_ack   = chg_ack_q;
  assign chg_err   = chg_err_q;

endmodule
